// File: rtl/tx_ddr_fill_dmac.sv
// TX DDR fill DMA: host AXIS stream -> fixed-length AXI4 INCR bursts
// into a DDR ring, with a held access_tick per committed packet.
module tx_ddr_fill_dmac #(
  parameter int BURST_LEN = 16,
  parameter int TICK_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  output logic         busy,
  input  logic [47:0]  base_address,
  input  logic [31:0]  ring_size_bytes,
  input  logic [16:0]  packet_bytes,
  output logic         access_tick,
  output logic [16:0]  access_size_bytes,
  output logic [31:0]  total_burst_count,
  output logic         write_error,
  input  logic [127:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [47:0]  m_axi_awaddr,
  output logic [7:0]   m_axi_awlen,
  output logic [2:0]   m_axi_awsize,
  output logic [1:0]   m_axi_awburst,
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [127:0] m_axi_wdata,
  output logic [15:0]  m_axi_wstrb,
  output logic         m_axi_wlast,
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  input  logic [1:0]   m_axi_bresp,
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready
);

  localparam logic [31:0] BB = 32'(BURST_LEN * 16);
  localparam logic [7:0] LAST = 8'(BURST_LEN - 1);
  localparam int TW = $clog2(TICK_HOLD + 1);
  localparam logic [TW-1:0] HOLD_M1 = TW'(TICK_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE, ARM, AW, W, B, CHECK
  } state_t;

  state_t state, state_nx;

  logic [47:0]   base_q;
  logic [31:0]   offset;
  logic [31:0]   pkt_cnt;
  logic [7:0]    beat;
  logic [TW-1:0] tick_cnt;
  logic          w_hs;
  logic          b_hs;
  logic          last_beat;
  logic          ring_wrap;
  logic          pkt_done;
  logic          bresp_err;

  assign w_hs      = m_axi_wvalid & m_axi_wready;
  assign b_hs      = (state == B) & m_axi_bvalid;
  assign last_beat = beat == LAST;
  assign ring_wrap = (offset + BB) == ring_size_bytes;
  assign pkt_done  = (pkt_cnt + BB) == {15'd0, access_size_bytes};
  assign bresp_err = m_axi_bresp inside {2'b10, 2'b11};

  assign m_axi_awlen   = LAST;
  assign m_axi_awsize  = 3'h4;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = 16'hFFFF;
  assign m_axi_wdata   = s_axis_tdata;

  // W is a zero-latency pass-through: host stalls stall the burst
  assign busy          = state != IDLE;
  assign m_axi_awvalid = state == AW;
  assign m_axi_wvalid  = (state == W) & s_axis_tvalid;
  assign s_axis_tready = (state == W) & m_axi_wready;
  assign m_axi_wlast   = (state == W) & last_beat;
  assign m_axi_bready  = state == B;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (enable) state_nx = ARM;
      ARM: begin
        if (!enable) state_nx = IDLE;
        else if (s_axis_tvalid) state_nx = AW;
      end
      AW:    if (m_axi_awready) state_nx = W;
      W:     if (w_hs && last_beat) state_nx = B;
      B:     if (m_axi_bvalid) state_nx = CHECK;
      CHECK: begin
        if (write_error || !enable) state_nx = IDLE;
        else state_nx = ARM;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      base_q            <= base_address;
      m_axi_awaddr      <= base_address;
      offset            <= '0;
      pkt_cnt           <= '0;
      beat              <= '0;
      total_burst_count <= '0;
      write_error       <= 1'b0;
      access_size_bytes <= '0;
      access_tick       <= 1'b0;
      tick_cnt          <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          base_q       <= base_address;
          m_axi_awaddr <= base_address;
          offset       <= '0;
          pkt_cnt      <= '0;
          if (enable) begin
            write_error       <= 1'b0;
            total_burst_count <= '0;
            access_size_bytes <= packet_bytes;
          end
        end
        AW: if (m_axi_awready) beat <= '0;
        W:  if (w_hs) beat <= beat + 8'd1;
        B: begin
          if (m_axi_bvalid) begin
            write_error       <= write_error | bresp_err;
            total_burst_count <= total_burst_count + 32'd1;
            if (ring_wrap) begin
              offset       <= '0;
              m_axi_awaddr <= base_q;
            end else begin
              offset       <= offset + BB;
              m_axi_awaddr <= m_axi_awaddr + {16'd0, BB};
            end
            pkt_cnt <= pkt_done ? '0 : pkt_cnt + BB;
          end
        end
        default: ;
      endcase
      // a packet finishing while the tick is held just restarts the hold
      if (b_hs && pkt_done) begin
        access_tick <= 1'b1;
        tick_cnt    <= HOLD_M1;
      end else if (access_tick) begin
        if (tick_cnt == '0) access_tick <= 1'b0;
        else tick_cnt <= tick_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_ddr_fill_dmac.sv
// Bench for tx_ddr_fill_dmac: scenario table driven through a random AXI
// slave / host model; ring addresses, data order and ticks from plain math.
module tb_tx_ddr_fill_dmac;

  localparam int BL = 16;
  localparam int TH = 4;
  localparam longint BB = BL * 16;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         busy;
  logic [47:0]  base_address;
  logic [31:0]  ring_size_bytes;
  logic [16:0]  packet_bytes;
  logic         access_tick;
  logic [16:0]  access_size_bytes;
  logic [31:0]  total_burst_count;
  logic         write_error;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [47:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_awvalid;
  logic         m_axi_awready;
  logic [127:0] m_axi_wdata;
  logic [15:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_wvalid;
  logic         m_axi_wready;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid;
  logic         m_axi_bready;

  tx_ddr_fill_dmac #(.BURST_LEN(BL), .TICK_HOLD(TH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .busy(busy),
    .base_address(base_address),
    .ring_size_bytes(ring_size_bytes),
    .packet_bytes(packet_bytes),
    .access_tick(access_tick),
    .access_size_bytes(access_size_bytes),
    .total_burst_count(total_burst_count),
    .write_error(write_error),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] base;
    logic [31:0] ring;
    logic [16:0] pkt;
    int          nb;
    int          drop;
    int          errb;
    bit          rnd;
    int          exp_count;
    bit          exp_err;
  } vec_t;

  vec_t tbl[7];
  vec_t cur;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  bit          rst_drv;
  bit          en;
  bit          track;
  bit          in_burst;
  bit          bpend;
  bit          bpend_err;
  int          beat;
  int          tick_rem;
  int          aw_n;
  int          bcount;
  int          scn_beats;
  int unsigned host_idx;
  int unsigned wcount;

  function automatic logic [127:0] pat(int unsigned i);
    int unsigned m;
    m = i * 32'h9E37_79B9;
    return {i, ~i, m, 32'hA5A5_0000 ^ i};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    in_burst = 0; bpend = 0; bpend_err = 0; beat = 0;
    tick_rem = 0; aw_n = 0; bcount = 0; scn_beats = 0;
  endtask

  task automatic observe();
    logic [47:0] exp_a;
    chk("chan", 128'({s_axis_tready, m_axi_wvalid, m_axi_bready}),
        128'({in_burst && m_axi_wready, in_burst && s_axis_tvalid, bpend}));
    chk("tick", 128'(access_tick), 128'(tick_rem != 0));
    if (tick_rem != 0) tick_rem--;
    if (m_axi_awvalid) chk("aw_idle", 128'(in_burst || bpend), 128'(0));
    if (m_axi_awvalid && m_axi_awready) begin
      exp_a = cur.base +
        48'((64'(aw_n) * 64'(BB)) % 64'(cur.ring));
      chk("awaddr", 128'(m_axi_awaddr), 128'(exp_a));
      chk("awattr", 128'({m_axi_awlen, m_axi_awsize, m_axi_awburst}),
          128'({8'(BL - 1), 3'd4, 2'b01}));
      aw_n++; in_burst = 1; beat = 0;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      chk("wdata", m_axi_wdata, pat(wcount));
      chk("wlast", 128'({m_axi_wlast, m_axi_wstrb}),
          128'({beat == BL - 1, 16'hFFFF}));
      wcount++; beat++; scn_beats++;
      if (beat == BL) begin
        in_burst = 0; bpend = 1;
        bpend_err = (bcount + 1 == cur.errb);
      end
      if (scn_beats == cur.drop) en = 0;
    end
    if (s_axis_tvalid && s_axis_tready) host_idx++;
    if (m_axi_bvalid && m_axi_bready) begin
      bpend = 0; bcount++;
      if ((longint'(bcount) * BB) % longint'(cur.pkt) == 0) tick_rem = TH;
      if (bcount == cur.errb || bcount == cur.nb) en = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst_n = rst_drv;
    enable = en;
    s_axis_tvalid = cur.rnd ? ($urandom_range(3) != 0) : 1'b1;
    s_axis_tdata = pat(host_idx);
    m_axi_awready = cur.rnd ? ($urandom_range(2) != 0) : 1'b1;
    m_axi_wready = cur.rnd ? ($urandom_range(3) != 0) : 1'b1;
    m_axi_bvalid = bpend && (cur.rnd ? ($urandom_range(2) != 0) : 1'b1);
    m_axi_bresp = (bpend && bpend_err) ? 2'b10 : 2'b00;
    #1;
    if (track && rst_n) observe();
  endtask

  task automatic do_reset();
    track = 0; rst_drv = 0; en = 0;
    repeat (3) step();
    clear_model();
    rst_drv = 1; track = 1;
    step();
  endtask

  task automatic run(input vec_t v);
    bit first;
    bit done;
    int cyc;
    cur = v;
    base_address = v.base;
    ring_size_bytes = v.ring;
    packet_bytes = v.pkt;
    aw_n = 0; bcount = 0; scn_beats = 0;
    first = 1; done = 0; cyc = 0;
    en = 1;
    while (!done && cyc < 30000) begin
      step();
      cyc++;
      if (busy && first) begin
        chk("arm_clear", 128'({write_error, total_burst_count}), 128'(0));
        chk("size", 128'(access_size_bytes), 128'(v.pkt));
        first = 0;
      end
      if (!en && !busy) done = 1;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL timeout: scenario base %0h bursts %0d", v.base, bcount);
      do_reset();
    end
    chk("bursts", 128'(bcount), 128'(v.exp_count));
    chk("count", 128'(total_burst_count), 128'(v.exp_count));
    chk("werr", 128'(write_error), 128'(v.exp_err));
    chk("busy", 128'(busy), 128'(0));
  endtask

  initial begin
    tbl[0] = '{48'h0000_1000_0000, 32'd1024, 17'd512, 4, -1, 0, 0, 4, 0};
    tbl[1] = '{48'h0000_2000_0000, 32'd4096, 17'd1024, 64, -1, 0, 1, 64, 0};
    tbl[2] = '{48'h0000_3000_0100, 32'd2048, 17'd512, 10, -1, 3, 1, 3, 1};
    tbl[3] = '{48'h0000_1000_0000, 32'd1024, 17'd512, 0, 7, 0, 0, 1, 0};
    tbl[4] = '{48'h0000_4000_0000, 32'd768, 17'd256, 7, -1, 0, 1, 7, 0};
    tbl[5] = '{48'h8000_0000_0000, 32'h0002_0000, 17'h1_0000,
               256, -1, 0, 0, 256, 0};
    tbl[6] = '{48'h0000_5000_0000, 32'd1024, 17'd512, 0, -1, 0, 0, 0, 0};

    cur = tbl[0];
    base_address = tbl[0].base;
    ring_size_bytes = tbl[0].ring;
    packet_bytes = tbl[0].pkt;
    m_axi_bresp = 2'b00;
    host_idx = 0; wcount = 0;
    clear_model();
    track = 0; rst_drv = 0; en = 0;
    repeat (3) step();
    chk("rst_ctl", 128'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
        s_axis_tready, access_tick, busy, write_error}), 128'(0));
    chk("rst_cnt", 128'(total_burst_count), 128'(0));
    chk("rst_addr", 128'(m_axi_awaddr), 128'(tbl[0].base));
    rst_drv = 1; track = 1;
    step();

    for (int i = 0; i < 6; i++) run(tbl[i]);

    // reset while beat 5 of a burst is in flight
    cur = tbl[6];
    base_address = tbl[6].base;
    ring_size_bytes = tbl[6].ring;
    packet_bytes = tbl[6].pkt;
    aw_n = 0; bcount = 0; scn_beats = 0;
    en = 1;
    for (int c = 0; c < 200 && scn_beats < 5; c++) step();
    chk("rst_beats", 128'(scn_beats), 128'(5));
    track = 0; rst_drv = 0; en = 0;
    step();
    step();
    chk("mid_rst_ctl", 128'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
        s_axis_tready, access_tick, busy, write_error}), 128'(0));
    chk("mid_rst_cnt", 128'(total_burst_count), 128'(0));
    chk("mid_rst_addr", 128'(m_axi_awaddr), 128'(tbl[6].base));
    clear_model();
    rst_drv = 1; track = 1;
    step();

    run(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
